// File: rtl/pq_pkg.sv
// Shared definitions for the instruction prefetch queue: fetch FSM encoding
// and the instruction length decode applied to the oldest queued byte.
package pq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Opcodes with a high nibble of D, E or F carry a 16-bit extension.
    function automatic logic [2:0] instr_len(input logic [7:0] b0);
        return (b0 >= 8'hD0) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Byte circular buffer: 2-byte push, 2/4-byte pop, 4-byte head window with
// bytes beyond the current fill level forced to zero.
module pq_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    input  logic                     pop4,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              peek
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   push_n;
    logic [AW:0]   pop_n;

    assign push_n = push ? (AW+1)'(2) : '0;
    assign pop_n  = pop ? (pop4 ? (AW+1)'(4) : (AW+1)'(2)) : '0;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr]          <= push_data[15:8];
            mem[wr_ptr + AW'(1)] <= push_data[7:0];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + pop_n[AW-1:0];
            wr_ptr <= wr_ptr + push_n[AW-1:0];
            count  <= count + push_n - pop_n;
        end
    end

    always_comb begin
        peek = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (count > (AW+1)'(i))
                peek[8*(3-i) +: 8] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words into a byte FIFO and hands
// the decoder 2- or 4-byte instructions through a registered ack/window pair.
module prefetch_queue
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter logic [15:0] RST_ADR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rqi_p,
    output logic        aki_n,
    output logic [31:0] cmd,
    output logic        mem_rq_p,
    input  logic        mem_ak_n,
    output logic [15:0] mem_adr,
    input  logic [15:0] mem_din,
    input  logic        flush_p,
    input  logic [15:0] flush_adr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [1:0]    state;
    logic [15:0]   flush_lat;
    logic [15:0]   flush_even;
    logic [CW-1:0] fifo_count;
    logic [31:0]   peek;
    logic [2:0]    head_len;
    logic          ack_ok;
    logic          push;
    logic          pop;
    logic          pop4;
    logic          room;

    assign flush_even = flush_adr & 16'hFFFE;
    assign head_len   = instr_len(peek[31:24]);
    assign ack_ok     = rqi_p && !aki_n && !flush_p && (fifo_count >= CW'(head_len));
    // The head cannot move while aki_n is high, so cmd still describes it.
    assign pop        = aki_n && !flush_p;
    assign pop4       = (instr_len(cmd[31:24]) == 3'd4);
    assign push       = (state == ST_WAIT) && mem_ak_n && !flush_p;
    assign room       = (fifo_count <= CW'(DEPTH - 2));

    pq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_p),
        .push      (push),
        .push_data (mem_din),
        .pop       (pop),
        .pop4      (pop4),
        .count     (fifo_count),
        .peek      (peek)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aki_n <= 1'b0;
            cmd   <= '0;
        end else begin
            aki_n <= ack_ok;
            if (ack_ok)
                cmd <= peek;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_rq_p  <= 1'b0;
            mem_adr   <= RST_ADR;
            flush_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_p) begin
                        mem_adr <= flush_even;
                    end else if (room) begin
                        mem_rq_p <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A flush coinciding with the ack drops the data immediately.
                    if (mem_ak_n) begin
                        mem_rq_p <= 1'b0;
                        state    <= ST_IDLE;
                        mem_adr  <= flush_p ? flush_even : mem_adr + 16'd2;
                    end else if (flush_p) begin
                        flush_lat <= flush_even;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ak_n) begin
                        mem_rq_p <= 1'b0;
                        state    <= ST_IDLE;
                        mem_adr  <= flush_p ? flush_even : flush_lat;
                    end else if (flush_p) begin
                        flush_lat <= flush_even;
                    end
                end
                default: begin
                    mem_rq_p <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: byte-queue reference model plus a latency-randomised
// memory responder, directed scenarios and a randomised soak.
module tb_prefetch_queue;

    localparam int unsigned DEPTH   = 8;
    localparam logic [15:0] RST_ADR = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rqi_p;
    logic        aki_n;
    logic [31:0] cmd;
    logic        mem_rq_p;
    logic        mem_ak_n;
    logic [15:0] mem_adr;
    logic [15:0] mem_din;
    logic        flush_p;
    logic [15:0] flush_adr;

    always #5 clk = ~clk;

    prefetch_queue #(
        .DEPTH   (DEPTH),
        .RST_ADR (RST_ADR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rqi_p     (rqi_p),
        .aki_n     (aki_n),
        .cmd       (cmd),
        .mem_rq_p  (mem_rq_p),
        .mem_ak_n  (mem_ak_n),
        .mem_adr   (mem_adr),
        .mem_din   (mem_din),
        .flush_p   (flush_p),
        .flush_adr (flush_adr)
    );

    int total = 0;
    int bad   = 0;

    // reference model
    logic [7:0]  q[$];
    logic [15:0] next_adr;
    bit          discard;
    // memory responder
    logic [15:0] words[$];
    bit          mem_block;
    int unsigned mem_lat;
    int unsigned wait_cnt;
    // observations
    int          fetches;
    int          acks;
    logic [15:0] ack_adrs[$];
    logic        exp_aki;
    logic        exp_rq;
    logic [31:0] exp_win;
    bit          adr_chk;
    logic [15:0] exp_adr;
    logic [15:0] got_adr;

    function automatic int len_of(input logic [7:0] b);
        return (b[7:4] > 4'hC) ? 4 : 2;
    endfunction

    function automatic logic [31:0] window();
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++)
            if (i < q.size()) w[31-8*i -: 8] = q[i];
        return w;
    endfunction

    // Advance one clock: drive the memory side, record what the model predicts
    // for the coming edge, then apply that edge's pops/pushes/flush to the model.
    task automatic step();
        bit ak_pre, aki_pre, fl_pre, rq_pre, rqi_pre;
        logic [15:0] fa_pre, din_pre;
        logic [7:0]  tmp;
        int sz, n;
        if (mem_ak_n) begin
            mem_ak_n = 1'b0;
        end else if (!mem_rq_p) begin
            wait_cnt = mem_lat;
        end else if (!mem_block) begin
            if (wait_cnt == 0) begin
                mem_ak_n = 1'b1;
                mem_din  = (words.size() > 0) ? words.pop_front() : 16'($urandom);
                wait_cnt = mem_lat;
            end else begin
                wait_cnt--;
            end
        end
        rqi_pre = rqi_p;  aki_pre = aki_n;  fl_pre = flush_p;  fa_pre = flush_adr;
        rq_pre  = mem_rq_p; ak_pre = mem_ak_n; din_pre = mem_din;
        sz      = q.size();
        exp_aki = rqi_pre && !aki_pre && !fl_pre && sz >= 2 && sz >= len_of(q[0]);
        exp_win = window();
        exp_rq  = rq_pre ? !ak_pre : (!fl_pre && (sz + 2 <= int'(DEPTH)));
        adr_chk = ak_pre && !discard && !fl_pre;
        exp_adr = next_adr;
        got_adr = mem_adr;
        if (ak_pre) begin
            fetches++;
            ack_adrs.push_back(mem_adr);
        end
        @(posedge clk);
        #1;
        if (aki_pre && !fl_pre && q.size() > 0) begin
            n = len_of(q[0]);
            for (int i = 0; i < n; i++)
                if (q.size() > 0) tmp = q.pop_front();
        end
        if (ak_pre) begin
            if (!discard && !fl_pre) begin
                q.push_back(din_pre[15:8]);
                q.push_back(din_pre[7:0]);
                next_adr += 16'd2;
            end
            discard = 0;
        end
        if (fl_pre) begin
            q.delete();
            next_adr = fa_pre & 16'hFFFE;
            if (rq_pre && !ak_pre) discard = 1;
        end
        if (aki_n) acks++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rqi_p = 1'b0; flush_p = 1'b0; flush_adr = '0;
        mem_ak_n = 1'b0; mem_din = '0; mem_block = 0; mem_lat = 0; wait_cnt = 0;
        words.delete(); q.delete(); ack_adrs.delete();
        next_adr = RST_ADR; discard = 0; fetches = 0; acks = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (aki_n !== 1'b0) begin bad++; $display("FAIL reset_aki: got %0b want 0", aki_n); end
        total++; if (cmd !== 32'h0) begin bad++; $display("FAIL reset_cmd: got %h want 0", cmd); end
        total++; if (mem_rq_p !== 1'b0) begin bad++; $display("FAIL reset_rq: got %0b want 0", mem_rq_p); end
        total++; if (mem_adr !== RST_ADR) begin bad++; $display("FAIL reset_adr: got %h want %h", mem_adr, RST_ADR); end
        total++; if (dut.fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.fifo_count); end
        rqi_p = 1'b1;
        for (int i = 0; i < 12; i++) step();
        mem_block = 1;
        for (int i = 0; i < 8 && !mem_rq_p; i++) step();
        total++; if (mem_rq_p !== 1'b1) begin bad++; $display("FAIL reset_pre_rq: got %0b want 1", mem_rq_p); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_rq_p !== 1'b0) begin bad++; $display("FAIL async_rq: got %0b want 0", mem_rq_p); end
        total++; if (mem_adr !== RST_ADR) begin bad++; $display("FAIL async_adr: got %h want %h", mem_adr, RST_ADR); end
        total++; if (cmd !== 32'h0) begin bad++; $display("FAIL async_cmd: got %h want 0", cmd); end
    endtask

    task automatic test_basic();
        do_reset();
        words = '{16'h1234, 16'h5678};
        for (int i = 0; i < 20 && fetches < 2; i++) step();
        mem_block = 1;
        total++; if (fetches !== 2) begin bad++; $display("FAIL basic_fetches: got %0d want 2", fetches); end
        total++; if (ack_adrs.size() < 2 || ack_adrs[0] !== 16'h0000 || ack_adrs[1] !== 16'h0002) begin
            bad++; $display("FAIL basic_adrs: got %p want 0000,0002", ack_adrs); end
        step();
        rqi_p = 1'b1;
        step();
        rqi_p = 1'b0;
        total++; if (aki_n !== 1'b1) begin bad++; $display("FAIL basic_aki: got %0b want 1", aki_n); end
        total++; if (cmd !== 32'h12345678) begin bad++; $display("FAIL basic_cmd: got %h want 12345678", cmd); end
        total++; if (dut.fifo_count !== 4) begin bad++; $display("FAIL basic_count_pre: got %0d want 4", dut.fifo_count); end
        step();
        total++; if (aki_n !== 1'b0) begin bad++; $display("FAIL basic_aki_low: got %0b want 0", aki_n); end
        total++; if (dut.fifo_count !== 2) begin bad++; $display("FAIL basic_count_post: got %0d want 2", dut.fifo_count); end
    endtask

    task automatic test_long();
        do_reset();
        words = '{16'hD012, 16'hABCD};
        rqi_p = 1'b1;
        for (int i = 0; i < 30 && acks < 1; i++) begin
            step();
            if (fetches >= 2) mem_block = 1;
            total++; if (aki_n !== exp_aki) begin bad++; $display("FAIL long_aki cyc %0d: got %0b want %0b", i, aki_n, exp_aki); end
        end
        rqi_p = 1'b0;
        total++; if (acks !== 1) begin bad++; $display("FAIL long_acks: got %0d want 1", acks); end
        total++; if (fetches !== 2) begin bad++; $display("FAIL long_fetches_at_ack: got %0d want 2", fetches); end
        total++; if (cmd !== 32'hD012ABCD) begin bad++; $display("FAIL long_cmd: got %h want D012ABCD", cmd); end
        step();
        total++; if (dut.fifo_count !== 0) begin bad++; $display("FAIL long_count: got %0d want 0", dut.fifo_count); end
    endtask

    task automatic test_full();
        do_reset();
        words = '{16'h1234, 16'h5678, 16'h9ABC, 16'h1122};
        mem_lat = $urandom_range(0, 2);
        for (int i = 0; i < 40; i++) step();
        total++; if (fetches !== 4) begin bad++; $display("FAIL full_fetches: got %0d want 4", fetches); end
        total++; if (dut.fifo_count !== DEPTH) begin bad++; $display("FAIL full_count: got %0d want %0d", dut.fifo_count, DEPTH); end
        total++; if (mem_rq_p !== 1'b0) begin bad++; $display("FAIL full_rq: got %0b want 0", mem_rq_p); end
        rqi_p = 1'b1;
        step();
        rqi_p = 1'b0;
        total++; if (cmd !== 32'h12345678 || aki_n !== 1'b1) begin
            bad++; $display("FAIL full_pop_ack: got aki=%0b cmd=%h want 1 12345678", aki_n, cmd); end
        for (int i = 0; i < 12; i++) step();
        total++; if (fetches !== 5) begin bad++; $display("FAIL full_refetch: got %0d want 5", fetches); end
        total++; if (ack_adrs.size() < 5 || ack_adrs[4] !== 16'h0008) begin
            bad++; $display("FAIL full_refetch_adr: got %p want [4]=0008", ack_adrs); end
        total++; if (mem_rq_p !== 1'b0) begin bad++; $display("FAIL full_rq_again: got %0b want 0", mem_rq_p); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        mem_block = 1;
        for (int i = 0; i < 5 && !mem_rq_p; i++) step();
        flush_p = 1'b1; flush_adr = 16'h4001;
        step();
        flush_p = 1'b0;
        total++; if (mem_rq_p !== 1'b1) begin bad++; $display("FAIL drain_rq_held: got %0b want 1", mem_rq_p); end
        words = '{16'hFFFF, 16'h1111};
        step();
        step();
        mem_block = 0; wait_cnt = 0;
        step();
        total++; if (fetches !== 1 || dut.fifo_count !== 0) begin
            bad++; $display("FAIL drain_discard: got fetches=%0d count=%0d want 1 0", fetches, dut.fifo_count); end
        for (int i = 0; i < 10 && fetches < 2; i++) step();
        total++; if (ack_adrs.size() < 2 || ack_adrs[1] !== 16'h4000) begin
            bad++; $display("FAIL drain_next_adr: got %p want [1]=4000", ack_adrs); end
        total++; if (window() !== 32'h11110000 || dut.fifo_count !== 2) begin
            bad++; $display("FAIL drain_refill: got count=%0d want 2", dut.fifo_count); end
    endtask

    task automatic test_flush_ack();
        do_reset();
        words = '{16'h1234, 16'h5678};
        for (int i = 0; i < 20 && fetches < 2; i++) step();
        mem_block = 1;
        rqi_p = 1'b1; flush_p = 1'b1; flush_adr = 16'h0100;
        step();
        flush_p = 1'b0; rqi_p = 1'b0;
        total++; if (aki_n !== 1'b0) begin bad++; $display("FAIL flush_ack_aki: got %0b want 0", aki_n); end
        total++; if (dut.fifo_count !== 0) begin bad++; $display("FAIL flush_ack_count: got %0d want 0", dut.fifo_count); end
        step();
        total++; if (aki_n !== 1'b0 || acks !== 0) begin bad++; $display("FAIL flush_ack_late: got aki=%0b acks=%0d want 0 0", aki_n, acks); end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_block = 1; flush_p = 1'b1; flush_adr = 16'hFFFE;
        step();
        flush_p = 1'b0; mem_block = 0;
        for (int i = 0; i < 20 && fetches < 2; i++) step();
        total++; if (ack_adrs.size() < 2 || ack_adrs[0] !== 16'hFFFE || ack_adrs[1] !== 16'h0000) begin
            bad++; $display("FAIL wrap_adrs: got %p want FFFE,0000", ack_adrs); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rqi_p     = ($urandom_range(0, 3) != 0);
            flush_p   = ($urandom_range(0, 49) == 0);
            flush_adr = 16'($urandom);
            mem_block = ($urandom_range(0, 7) == 0);
            mem_lat   = $urandom_range(0, 3);
            step();
            total++; if (aki_n !== exp_aki) begin bad++; $display("FAIL rnd_aki cyc %0d: got %0b want %0b", i, aki_n, exp_aki); end
            total++; if (mem_rq_p !== exp_rq) begin bad++; $display("FAIL rnd_rq cyc %0d: got %0b want %0b", i, mem_rq_p, exp_rq); end
            total++; if (dut.fifo_count !== q.size()) begin bad++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", i, dut.fifo_count, q.size()); end
            if (exp_aki) begin
                total++; if (cmd !== exp_win) begin bad++; $display("FAIL rnd_cmd cyc %0d: got %h want %h", i, cmd, exp_win); end
            end
            if (adr_chk) begin
                total++; if (got_adr !== exp_adr) begin bad++; $display("FAIL rnd_adr cyc %0d: got %h want %h", i, got_adr, exp_adr); end
            end
        end
        flush_p = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long();
        test_full();
        test_flush_wait();
        test_flush_ack();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
